fifo_data_pack: RTL and testbench
=================================

Name: fifo_data_pack

Overview:
- Write-side packer for the 140-bit channel FIFO word.
- Accepts a stream of 16-bit words, each tagged with an 8-bit channel-select, over a valid/ready handshake.
- Assembles up to 8 words MSB-first into one FIFO word: data[139:12], channel[11:4], length code[3:0] = word count.
- Writes the word into the FIFO, honouring fifo_full back-pressure.

Parameters:
- DATA_W, 16, width of one input word
- MAX_WORDS, 8, words per FIFO entry; length code range 1..MAX_WORDS
- CH_W, 8, channel-select width
- CNT_W, 16, width of the saturating frame counter

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- din  in  16  input data word
- din_ch  in  8  channel-select tag for din
- din_last  in  1  din is the final word of its frame
- din_vld  in  1  din/din_ch/din_last valid
- din_rdy  out  1  packer can accept; transfer when din_vld && din_rdy
- fifo_full  in  1  FIFO cannot accept a write this cycle
- fifo_wr_en  out  1  one-cycle write strobe
- data_to_fifo  out  140  packed word {data[127:0], ch[7:0], len[3:0]}
- err_ch_zero  out  1  one-cycle pulse: accepted word had din_ch == 0 and was discarded
- frame_cnt  out  16  count of FIFO words written, saturating at 16'hFFFF

Behaviour:
- Reset (sync, rst=1 at an edge) values: din_rdy=0, fifo_wr_en=0, data_to_fifo=0, err_ch_zero=0, frame_cnt=0, state=IDLE, word index=0.
- Any partial frame in progress when rst rises is discarded; no write is issued.
- FSM states:
  - IDLE: din_rdy=1, no frame open.
  - FILL: din_rdy=1, frame open, index k in 1..7.
  - FLUSH: din_rdy=0, packed word held, waiting on the FIFO.
- Word placement: the word at index k (0-based) goes to data bits [139-16k : 124-16k]. Bits not written in a frame are 0.
- Length code = number of words in the frame, 1..8. Codes 0 and 9..15 are never produced.
- Channel:
  - latched from the frame's first word into [11:4];
  - zero-channel words: accepted, not stored, err_ch_zero pulses the next cycle, state and index unchanged.
- IDLE + transfer, non-zero channel:
  - store at index 0, latch channel;
  - if din_last, go to FLUSH with len=1; else go to FILL with k=1.
- FILL + transfer, same channel:
  - store at index k;
  - if din_last or k == 7, go to FLUSH with len=k+1; else k+1.
- FILL + din_vld with a different non-zero channel:
  - the word is NOT consumed: din_rdy is forced 0 that cycle (combinational compare);
  - go to FLUSH with len=k; the held word is taken from IDLE after the flush.
- FLUSH:
  - each cycle with fifo_full=0: fifo_wr_en=1 for exactly one cycle, data_to_fifo stable during the strobe, frame_cnt+1 (saturating), return to IDLE;
  - fifo_full=1: hold word and stay; fifo_wr_en=0.
- data_to_fifo is registered. It may change only on entering FLUSH and holds its value until the next FLUSH entry.
- Latency: closing word accepted in cycle N → fifo_wr_en in cycle N+1 if fifo_full=0.
- Throughput: one bubble per frame (din_rdy=0 during the FLUSH cycle).
- din_rdy never depends combinationally on fifo_full. It depends only on the state and the channel-mismatch compare.
- frame_cnt holds at 16'hFFFF; no wrap.

Decomposition:
- Shared package fifo_word_pkg, used by this block and the read-side resolver:
  - FIFO_W=140, DATA_W=16, MAX_WORDS=8, CH_W=8;
  - field LSBs LEN_LSB=0, CH_LSB=4, DATA_LSB=12;
  - len field width 4;
  - state enum {IDLE, FILL, FLUSH}.
- Single module with no sub-module.
- The placement shifter is a simple indexed part-select, not worth separating.

Test Plan:
- Single word 16'hA5A5, ch 8'h01, last=1, fifo_full=0 → next cycle fifo_wr_en=1, data_to_fifo = {16'hA5A5, 112'h0, 8'h01, 4'h1}, frame_cnt=1.
- Eight words 16'h0001..16'h0008 on ch 8'h80, last never set → write after the 8th word with data = 16'h0001…16'h0008 concatenated, len 4'h8; next frame starts cleanly.
- Three words on ch 8'h02, fourth word on ch 8'h04:
  - din_rdy=0 on the fourth word; write of len 3, ch 8'h02;
  - then the ch 8'h04 word is accepted as index 0 of a new frame.
- fifo_full=1 for 5 cycles after a frame closes → din_rdy=0 and no wr_en for those cycles, word unchanged; single wr_en on the first fifo_full=0 cycle.
- Word with din_ch=0 mid-frame → err_ch_zero pulses once, index unchanged, final len excludes it.
- rst asserted after 2 words of a frame → no write, all outputs at reset values; a subsequent 1-word frame produces len 1 and frame_cnt=1.

Source files
------------

// File: rtl/fifo_word_pkg.sv
// Shared layout of the 140-bit channel FIFO word.
// Used by the write-side packer and the read-side resolver.
package fifo_word_pkg;

    localparam int FIFO_W    = 140;
    localparam int DATA_W    = 16;
    localparam int MAX_WORDS = 8;
    localparam int CH_W      = 8;
    localparam int LEN_W     = 4;

    localparam int LEN_LSB  = 0;
    localparam int CH_LSB   = 4;
    localparam int DATA_LSB = 12;

    localparam int PAYLOAD_W = DATA_W * MAX_WORDS;
    localparam int IDX_W     = $clog2(MAX_WORDS);
    localparam int LSB_W     = $clog2(PAYLOAD_W);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH
    } pack_state_e;

    // Word 0 sits at the top of the payload, later words below it.
    function automatic logic [LSB_W-1:0] slot_lsb(logic [IDX_W-1:0] idx);
        return LSB_W'(PAYLOAD_W - DATA_W) - LSB_W'(32'(idx) * DATA_W);
    endfunction

    function automatic logic [FIFO_W-1:0] pack_word(
        logic [PAYLOAD_W-1:0] d,
        logic [CH_W-1:0]      ch,
        logic [LEN_W-1:0]     len
    );
        return {d, ch, len};
    endfunction

endpackage

// File: rtl/fifo_data_pack.sv
// Write-side packer: gathers up to eight tagged 16-bit words
// into one 140-bit FIFO entry and writes it under back-pressure.
module fifo_data_pack
    import fifo_word_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic [CH_W-1:0]   din_ch,
    input  logic              din_last,
    input  logic              din_vld,
    output logic              din_rdy,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [FIFO_W-1:0] data_to_fifo,
    output logic              err_ch_zero,
    output logic [CNT_W-1:0]  frame_cnt
);

    pack_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [PAYLOAD_W-1:0] buf_q, buf_d;
    logic [FIFO_W-1:0]    out_q, out_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic ch_zero;
    logic ch_mismatch;
    logic xfer;

    assign ch_zero     = (din_ch == '0);
    assign ch_mismatch = din_vld && !ch_zero && (din_ch != ch_q);

    // A word from another channel closes the open frame and waits.
    assign din_rdy = !rst && ((state_q == IDLE) ||
                              (state_q == FILL && !ch_mismatch));
    assign xfer    = din_vld && din_rdy;

    assign fifo_wr_en   = (state_q == FLUSH) && !fifo_full;
    assign data_to_fifo = out_q;
    assign err_ch_zero  = err_q;
    assign frame_cnt    = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        buf_d   = buf_q;
        out_d   = out_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (xfer && ch_zero) begin
                    err_d = 1'b1;
                end else if (xfer) begin
                    buf_d = {din, {(PAYLOAD_W - DATA_W){1'b0}}};
                    ch_d  = din_ch;
                    if (din_last) begin
                        state_d = FLUSH;
                        idx_d   = '0;
                        out_d   = pack_word(buf_d, din_ch, LEN_W'(1));
                    end else begin
                        state_d = FILL;
                        idx_d   = IDX_W'(1);
                    end
                end
            end
            FILL: begin
                if (ch_mismatch) begin
                    state_d = FLUSH;
                    idx_d   = '0;
                    out_d   = pack_word(buf_q, ch_q, LEN_W'(idx_q));
                end else if (xfer && ch_zero) begin
                    err_d = 1'b1;
                end else if (xfer) begin
                    buf_d[slot_lsb(idx_q) +: DATA_W] = din;
                    if (din_last || idx_q == IDX_W'(MAX_WORDS - 1)) begin
                        state_d = FLUSH;
                        idx_d   = '0;
                        out_d   = pack_word(buf_d, ch_q,
                                            LEN_W'(idx_q) + LEN_W'(1));
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (!fifo_full) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ch_q    <= '0;
            buf_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_data_pack.sv
// Bench for fifo_data_pack: directed table, corner sequences,
// and random traffic against a frame-queue reference model.
module tb_fifo_data_pack;

    logic         clk;
    logic         rst;
    logic [15:0]  din;
    logic [7:0]   din_ch;
    logic         din_last;
    logic         din_vld;
    logic         din_rdy;
    logic         fifo_full;
    logic         fifo_wr_en;
    logic [139:0] data_to_fifo;
    logic         err_ch_zero;
    logic [15:0]  frame_cnt;

    fifo_data_pack dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_ch      (din_ch),
        .din_last    (din_last),
        .din_vld     (din_vld),
        .din_rdy     (din_rdy),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .data_to_fifo(data_to_fifo),
        .err_ch_zero (err_ch_zero),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    function automatic void chk(string nm, logic [139:0] act, logic [139:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference model: the open frame is a queue of words.
    logic [15:0]  m_words[$];
    logic [7:0]   m_ch;
    bit           m_flush;
    logic [139:0] m_out;
    logic [15:0]  m_cnt;
    bit           m_err;

    function automatic void m_close();
        logic [127:0] d = '0;
        foreach (m_words[i]) d = (d << 16) | 128'(m_words[i]);
        d = d << (16 * (8 - m_words.size()));
        m_out = {d, m_ch, 4'(m_words.size())};
        m_words.delete();
        m_flush = 1;
    endfunction

    function automatic bit m_rdy();
        bit other;
        other = m_words.size() > 0 && din_vld && din_ch != 0 && din_ch != m_ch;
        return !rst && !m_flush && !other;
    endfunction

    function automatic void m_check();
        chk("rdy", 140'(din_rdy), 140'(m_rdy()));
        chk("wr_en", 140'(fifo_wr_en), 140'(m_flush && !fifo_full));
        chk("data", data_to_fifo, m_out);
        chk("err", 140'(err_ch_zero), 140'(m_err));
        chk("cnt", 140'(frame_cnt), 140'(m_cnt));
    endfunction

    function automatic void m_update();
        bit rdy;
        rdy = m_rdy();
        m_err = 0;
        if (rst) begin
            m_words.delete();
            m_flush = 0;
            m_out   = '0;
            m_cnt   = '0;
            m_ch    = '0;
        end else if (m_flush) begin
            if (!fifo_full) begin
                m_flush = 0;
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
        end else if (din_vld && !rdy) begin
            m_close();
        end else if (din_vld) begin
            if (din_ch == 0) begin
                m_err = 1;
            end else begin
                if (m_words.size() == 0) m_ch = din_ch;
                m_words.push_back(din);
                if (din_last || m_words.size() == 8) m_close();
            end
        end
    endfunction

    task automatic step(input bit r, input bit v, input logic [15:0] d,
                        input logic [7:0] c, input bit l, input bit f);
        @(negedge clk);
        rst       = r;
        din_vld   = v;
        din       = d;
        din_ch    = c;
        din_last  = l;
        fifo_full = f;
        #1;
        if (chk_en) m_check();
        m_update();
    endtask

    task automatic idle(input bit f);
        step(0, 0, 16'h0, 8'h0, 0, f);
    endtask

    typedef struct {
        bit           vld;
        logic [15:0]  d;
        logic [7:0]   ch;
        bit           last;
        bit           e_rdy;
        bit           e_wr;
        bit           e_err;
        logic [15:0]  e_cnt;
        bit           cd;
        logic [139:0] e_data;
    } vec_t;

    function automatic vec_t mk(bit v, logic [15:0] d, logic [7:0] c, bit l,
                                bit er, bit ew, bit ee, logic [15:0] ec,
                                bit cd, logic [139:0] ed);
        vec_t t;
        t.vld = v; t.d = d; t.ch = c; t.last = l;
        t.e_rdy = er; t.e_wr = ew; t.e_err = ee; t.e_cnt = ec;
        t.cd = cd; t.e_data = ed;
        return t;
    endfunction

    vec_t tbl[16];

    initial begin
        logic [139:0] z;
        z = '0;
        tbl[0]  = mk(1, 16'hA5A5, 8'h01, 1, 1, 0, 0, 0, 0, z);
        tbl[1]  = mk(0, 16'h0, 8'h00, 0, 0, 1, 0, 0, 1,
                     {16'hA5A5, 112'h0, 8'h01, 4'h1});
        tbl[2]  = mk(0, 16'h0, 8'h00, 0, 1, 0, 0, 1, 0, z);
        tbl[3]  = mk(1, 16'h1111, 8'h02, 0, 1, 0, 0, 1, 0, z);
        tbl[4]  = mk(1, 16'h2222, 8'h02, 0, 1, 0, 0, 1, 0, z);
        tbl[5]  = mk(1, 16'h3333, 8'h02, 0, 1, 0, 0, 1, 0, z);
        tbl[6]  = mk(1, 16'h4444, 8'h04, 1, 0, 0, 0, 1, 0, z);
        tbl[7]  = mk(1, 16'h4444, 8'h04, 1, 0, 1, 0, 1, 1,
                     {16'h1111, 16'h2222, 16'h3333, 80'h0, 8'h02, 4'h3});
        tbl[8]  = mk(1, 16'h4444, 8'h04, 1, 1, 0, 0, 2, 0, z);
        tbl[9]  = mk(0, 16'h0, 8'h00, 0, 0, 1, 0, 2, 1,
                     {16'h4444, 112'h0, 8'h04, 4'h1});
        tbl[10] = mk(0, 16'h0, 8'h00, 0, 1, 0, 0, 3, 0, z);
        tbl[11] = mk(1, 16'h0AAA, 8'h05, 0, 1, 0, 0, 3, 0, z);
        tbl[12] = mk(1, 16'h0BBB, 8'h00, 0, 1, 0, 0, 3, 0, z);
        tbl[13] = mk(1, 16'h0CCC, 8'h05, 1, 1, 0, 1, 3, 0, z);
        tbl[14] = mk(0, 16'h0, 8'h00, 0, 0, 1, 0, 3, 1,
                     {16'h0AAA, 16'h0CCC, 96'h0, 8'h05, 4'h2});
        tbl[15] = mk(0, 16'h0, 8'h00, 0, 1, 0, 0, 4, 0, z);

        rst = 1; din_vld = 0; din = '0; din_ch = '0;
        din_last = 0; fifo_full = 0;
        step(1, 0, 16'h0, 8'h0, 0, 0);
        chk_en = 1;
        step(1, 0, 16'h0, 8'h0, 0, 0);
        chk("rst_rdy", 140'(din_rdy), 140'(0));
        chk("rst_data", data_to_fifo, z);
        chk("rst_cnt", 140'(frame_cnt), 140'(0));

        foreach (tbl[i]) begin
            step(0, tbl[i].vld, tbl[i].d, tbl[i].ch, tbl[i].last, 0);
            chk($sformatf("tbl%0d_rdy", i), 140'(din_rdy), 140'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_wr", i), 140'(fifo_wr_en), 140'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_err", i), 140'(err_ch_zero), 140'(tbl[i].e_err));
            chk($sformatf("tbl%0d_cnt", i), 140'(frame_cnt), 140'(tbl[i].e_cnt));
            if (tbl[i].cd)
                chk($sformatf("tbl%0d_data", i), data_to_fifo, tbl[i].e_data);
        end

        // Eight words with no last marker close on the eighth.
        for (int i = 1; i <= 8; i++) step(0, 1, 16'(i), 8'h80, 0, 0);
        idle(0);
        chk("full8_wr", 140'(fifo_wr_en), 140'(1));
        chk("full8_data", data_to_fifo,
            {16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8,
             8'h80, 4'h8});
        idle(0);
        chk("full8_cnt", 140'(frame_cnt), 140'(5));
        step(0, 1, 16'hBEEF, 8'h33, 1, 0);
        idle(0);
        chk("after8_data", data_to_fifo, {16'hBEEF, 112'h0, 8'h33, 4'h1});
        idle(0);
        chk("after8_cnt", 140'(frame_cnt), 140'(6));

        // FIFO back-pressure holds the packed word.
        step(0, 1, 16'h1234, 8'h07, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 16'h5555, 8'h09, 1, 1);
            chk("bp_rdy", 140'(din_rdy), 140'(0));
            chk("bp_wr", 140'(fifo_wr_en), 140'(0));
            chk("bp_data", data_to_fifo, {16'h1234, 112'h0, 8'h07, 4'h1});
        end
        step(0, 1, 16'h5555, 8'h09, 1, 0);
        chk("bp_release_wr", 140'(fifo_wr_en), 140'(1));
        step(0, 1, 16'h5555, 8'h09, 1, 0);
        chk("bp_after_rdy", 140'(din_rdy), 140'(1));
        chk("bp_after_cnt", 140'(frame_cnt), 140'(7));
        idle(0);
        idle(0);

        // Reset in the middle of a frame drops it.
        step(0, 1, 16'hAAAA, 8'h06, 0, 0);
        step(0, 1, 16'hBBBB, 8'h06, 0, 0);
        step(1, 0, 16'h0, 8'h0, 0, 0);
        chk("mrst_rdy", 140'(din_rdy), 140'(0));
        idle(0);
        chk("mrst_wr", 140'(fifo_wr_en), 140'(0));
        chk("mrst_data", data_to_fifo, z);
        chk("mrst_cnt", 140'(frame_cnt), 140'(0));
        step(0, 1, 16'h7777, 8'h03, 1, 0);
        idle(0);
        chk("mrst_len1", data_to_fifo, {16'h7777, 112'h0, 8'h03, 4'h1});
        idle(0);
        chk("mrst_cnt1", 140'(frame_cnt), 140'(1));

        for (int i = 0; i < 2000; i++) begin
            int sel;
            logic [7:0] c;
            sel = $urandom_range(0, 9);
            c = (sel == 0) ? 8'h00 : (sel < 5) ? 8'h01 :
                (sel < 8) ? 8'h02 : 8'h80;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 7,
                 16'($urandom), c,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 3);
        end
        idle(0);
        idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
